pow_arbiter: RTL and testbench
==============================

# pow_arbiter

Round-robin front end that shares one `pow` (signed 16-bit base/exponent power) unit between `N` requesters. It accepts one operation at a time and sequences the unit's `start`/`ready` handshake. It captures `result`, `Cflag` and `Oflag` in the unit's single `ready` cycle and returns them tagged with the requester ID. A watchdog aborts operations that exceed a cycle budget. It sits between the client blocks and the `pow` instance at the top level.

## Interface

**Parameters**

- `N`, 4 — number of requesters (2..8).
- `TIMEOUT`, 40000 — maximum cycles spent in WAIT before abort; must be ≥ 2.

**Ports**

- `clk` in 1 — clock.
- `rst` in 1 — reset. One clock; reset is synchronous and active-high.
- `req_valid` in N — per-requester operation request.
- `req_base` in 16*N — base of requester i, in bits [16i+15:16i], signed.
- `req_expo` in 16*N — exponent of requester i, same packing, signed.
- `req_ack` out N — one-hot, single-cycle; the request is consumed when `req_valid[i] & req_ack[i]`.
- `rsp_valid` out 1 — single-cycle result strobe; there is no backpressure.
- `rsp_id` out $clog2(N) — requester the response belongs to.
- `rsp_result` out 32 — captured `pow` result.
- `rsp_cflag` out 1 — captured `Cflag`: 0^0 or negative exponent.
- `rsp_oflag` out 1 — captured `Oflag`: result overflowed signed 32 bits.
- `rsp_err` out 1 — operation aborted by the watchdog; `rsp_result` is 0 when this is set.
- `pow_start` out 1 — `start` to the unit.
- `pow_base` out 16 — `base` to the unit.
- `pow_expo` out 16 — `expo` to the unit.
- `pow_ready` in 1 — `ready` from the unit.
- `pow_result` in 32 — `result` from the unit.
- `pow_cflag` in 1 — `Cflag` from the unit.
- `pow_oflag` in 1 — `Oflag` from the unit.
- `pow_abort` out 1 — single-cycle pulse; the top level ORs it with `rst` into the unit's `rst`.

## Operation

- **States:** IDLE, ISSUE, WAIT, ABORT, RESP.
- **IDLE:**
  - If any `req_valid` is set, select the winner as the first set bit scanning upward from `rr_ptr`, wrapping modulo N.
  - Assert `req_ack[winner]` this cycle.
  - Latch the winner's base, expo and ID into `op_*` registers, then go to ISSUE.
  - With no valid request, stay in IDLE with `req_ack`=0.
- **ISSUE:** `pow_start`=1 for exactly one cycle. Clear the watchdog counter, then go to WAIT.
- **WAIT:**
  - If `pow_ready`, capture `pow_result`, `pow_cflag` and `pow_oflag`, clear err, and go to RESP.
  - Otherwise, when the counter reaches `TIMEOUT-1`, go to ABORT. Otherwise increment the counter.
  - `pow_ready` takes precedence over timeout in the same cycle.
- **ABORT:** `pow_abort`=1 for one cycle. Set err, set result and flags to 0, then go to RESP.
- **RESP:** `rsp_valid`=1 with `rsp_id`=`op_id`. Set `rr_ptr` to `op_id+1` mod N, then go to IDLE.
- **Operand drive:** `pow_base` and `pow_expo` are driven from the `op_*` registers in all states.
- **Response hold:** the `rsp_*` data outputs hold their last value between strobes.
- `pow_ready`/`pow_result` outside WAIT are ignored.
- A requester that drops `req_valid` before its ack is not served. No requester may be starved: within N operations, every continuously valid requester is served.

## Timing

- **Reset:**
  - All outputs are 0: `req_ack`, `rsp_*`, `pow_start`, `pow_base`, `pow_expo`, `pow_abort`.
  - `rr_ptr`=0, state IDLE, counter 0.
  - Reset mid-operation abandons the operation with no response. `rst` also resets the `pow` unit.
- **Unit latency:** `pow` asserts `ready` e+1 cycles after the `start` cycle for an exponent e ≥ 0. For a negative exponent (`expo[15]`=1) it is 1 cycle.
- **End-to-end latency:** ack in cycle A, `pow_start` in A+1, `rsp_valid` in A+e+3. A negative exponent gives A+3.
- **Abort path:** `rsp_valid` arrives in A+TIMEOUT+3.
- **Throughput:** the next ack is possible in the cycle after RESP. Minimum spacing between acks is e+4 cycles.
- **Unit timing:** `pow` is idle on the cycle after its `ready` and after an abort. ISSUE therefore always meets an idle unit.

## Structure

- **`pow_pkg`:** state enum `pow_arb_state_t`, `POW_W`=16, `POW_RES_W`=32.
- **Sub-module `rr_pick`:** combinational N-way round-robin selector. Inputs are the request vector and pointer; outputs are a one-hot grant plus an encoded index.
- **Top module:** FSM, `op_*` registers, watchdog counter of width $clog2(TIMEOUT) and response registers.

## Test plan

- Requester 0 sends base=3, expo=4 → `rsp_result`=81, cflag=0, oflag=0, err=0, id=0. `rsp_valid` arrives 7 cycles after the ack.
- Requester 2 sends base=−2 (0xFFFE), expo=3 → `rsp_result`=0xFFFFFFF8, id=2.
- Sends of base=0, expo=0 and of base=5, expo=0x8000 → both give cflag=1. The negative-exponent case arrives 3 cycles after the ack.
- base=2, expo=31 → `rsp_result`=0x80000000, oflag=1.
- All four `req_valid` held high with `rr_ptr`=0 → responses in ID order 0,1,2,3,0. No `req_ack` is asserted outside IDLE.
- TIMEOUT=8, base=1, expo=20 → `pow_abort` pulses once, then `rsp_err`=1 with result 0. A following base=2, expo=2 completes with 4. `rst` asserted during WAIT leaves no `rsp_valid` and returns all outputs to 0.

Source files
------------

// File: rtl/pow_arbiter_pkg.sv
// Shared types and widths for the pow arbiter slice.
package pow_arbiter_pkg;

   localparam int unsigned POW_W     = 16;
   localparam int unsigned POW_RES_W = 32;

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StWait,
      StAbort,
      StResp
   } pow_arb_state_t;

endpackage

// File: rtl/pow_arbiter_if.sv
// Client request/response and pow unit handshake bundle for the arbiter.
// slave: the arbiter side; master: the clients plus the pow unit.
interface pow_arbiter_if
   import pow_arbiter_pkg::*;
#(
   parameter int unsigned N = 4
) ();

   localparam int unsigned IDW = $clog2(N);

   logic [N-1:0]         req_valid;
   logic [POW_W*N-1:0]   req_base;
   logic [POW_W*N-1:0]   req_expo;
   logic [N-1:0]         req_ack;

   logic                 rsp_valid;
   logic [IDW-1:0]       rsp_id;
   logic [POW_RES_W-1:0] rsp_result;
   logic                 rsp_cflag;
   logic                 rsp_oflag;
   logic                 rsp_err;

   logic                 pow_start;
   logic [POW_W-1:0]     pow_base;
   logic [POW_W-1:0]     pow_expo;
   logic                 pow_ready;
   logic [POW_RES_W-1:0] pow_result;
   logic                 pow_cflag;
   logic                 pow_oflag;
   logic                 pow_abort;

   modport slave (
      input  req_valid, req_base, req_expo,
      input  pow_ready, pow_result, pow_cflag, pow_oflag,
      output req_ack,
      output rsp_valid, rsp_id, rsp_result, rsp_cflag, rsp_oflag, rsp_err,
      output pow_start, pow_base, pow_expo, pow_abort
   );

   modport master (
      output req_valid, req_base, req_expo,
      output pow_ready, pow_result, pow_cflag, pow_oflag,
      input  req_ack,
      input  rsp_valid, rsp_id, rsp_result, rsp_cflag, rsp_oflag, rsp_err,
      input  pow_start, pow_base, pow_expo, pow_abort
   );

endinterface

// File: rtl/pow_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr, wrapping modulo N.
module pow_arbiter_rr_pick #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] idx,
   output logic                 found
);

   int unsigned pos;

   // Scan N positions starting at ptr; the first hit wins.
   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      pos   = 0;
      for (int k = 0; k < int'(N); k++) begin
         pos = (32'(ptr) + 32'(k)) % N;
         if (!found && req[pos]) begin
            found      = 1'b1;
            grant[pos] = 1'b1;
            idx        = $clog2(N)'(pos);
         end
      end
   end

endmodule

// File: rtl/pow_arbiter.sv
// Round-robin front end sharing one pow unit between N requesters, with a WAIT watchdog.
module pow_arbiter
   import pow_arbiter_pkg::*;
#(
   parameter int unsigned N       = 4,
   parameter int unsigned TIMEOUT = 40000
) (
   input logic          clk,
   input logic          rst,
   pow_arbiter_if.slave bus
);

   localparam int unsigned IDW = $clog2(N);
   localparam int unsigned CW  = $clog2(TIMEOUT);

   pow_arb_state_t       state;
   logic [POW_W-1:0]     op_base;
   logic [POW_W-1:0]     op_expo;
   logic [IDW-1:0]       op_id;
   logic [IDW-1:0]       rr_ptr;
   logic [CW-1:0]        wd_cnt;

   logic                 pow_start;
   logic                 pow_abort;
   logic                 rsp_valid;
   logic [IDW-1:0]       rsp_id;
   logic [POW_RES_W-1:0] rsp_result;
   logic                 rsp_cflag;
   logic                 rsp_oflag;
   logic                 rsp_err;

   logic [N-1:0]         grant;
   logic [IDW-1:0]       win_idx;
   logic                 win_found;

   pow_arbiter_rr_pick #(
      .N (N)
   ) u_rr_pick (
      .req   (bus.req_valid),
      .ptr   (rr_ptr),
      .grant (grant),
      .idx   (win_idx),
      .found (win_found)
   );

   // Ack is combinational so the winner is consumed in the same IDLE cycle it is chosen.
   assign bus.req_ack    = (state == StIdle && !rst) ? grant : '0;

   assign bus.pow_start  = pow_start;
   assign bus.pow_abort  = pow_abort;
   assign bus.pow_base   = op_base;
   assign bus.pow_expo   = op_expo;
   assign bus.rsp_valid  = rsp_valid;
   assign bus.rsp_id     = rsp_id;
   assign bus.rsp_result = rsp_result;
   assign bus.rsp_cflag  = rsp_cflag;
   assign bus.rsp_oflag  = rsp_oflag;
   assign bus.rsp_err    = rsp_err;

   // Sequencer: accept, issue, wait/watchdog, abort, respond; strobes are registered pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= StIdle;
         op_base    <= '0;
         op_expo    <= '0;
         op_id      <= '0;
         rr_ptr     <= '0;
         wd_cnt     <= '0;
         pow_start  <= 1'b0;
         pow_abort  <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         rsp_result <= '0;
         rsp_cflag  <= 1'b0;
         rsp_oflag  <= 1'b0;
         rsp_err    <= 1'b0;
      end else begin
         pow_start <= 1'b0;
         pow_abort <= 1'b0;
         rsp_valid <= 1'b0;
         unique case (state)
            StIdle: begin
               if (win_found) begin
                  op_base   <= bus.req_base[POW_W*win_idx +: POW_W];
                  op_expo   <= bus.req_expo[POW_W*win_idx +: POW_W];
                  op_id     <= win_idx;
                  pow_start <= 1'b1;
                  state     <= StIssue;
               end
            end
            StIssue: begin
               wd_cnt <= '0;
               state  <= StWait;
            end
            StWait: begin
               // ready wins over an expiring watchdog in the same cycle
               if (bus.pow_ready) begin
                  rsp_result <= bus.pow_result;
                  rsp_cflag  <= bus.pow_cflag;
                  rsp_oflag  <= bus.pow_oflag;
                  rsp_err    <= 1'b0;
                  rsp_id     <= op_id;
                  rsp_valid  <= 1'b1;
                  state      <= StResp;
               end else if (wd_cnt == CW'(TIMEOUT - 1)) begin
                  pow_abort <= 1'b1;
                  state     <= StAbort;
               end else begin
                  wd_cnt <= wd_cnt + CW'(1);
               end
            end
            StAbort: begin
               rsp_result <= '0;
               rsp_cflag  <= 1'b0;
               rsp_oflag  <= 1'b0;
               rsp_err    <= 1'b1;
               rsp_id     <= op_id;
               rsp_valid  <= 1'b1;
               state      <= StResp;
            end
            StResp: begin
               rr_ptr <= (op_id == IDW'(N - 1)) ? '0 : op_id + IDW'(1);
               state  <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_pow_arbiter.sv
// Bench for pow_arbiter: behavioural pow unit models, directed vector table,
// round-robin and reset sequences, then randomized contention against a reference model.
module tb_pow_arbiter;
   import pow_arbiter_pkg::*;

   localparam int unsigned N = 4;

   typedef struct packed {
      logic        valid;
      logic [1:0]  id;
      logic [31:0] result;
      logic        c;
      logic        o;
      logic        err;
   } rsp_t;

   typedef struct {
      int          sel;
      int          id;
      logic [15:0] b;
      logic [15:0] e;
      logic [31:0] r;
      logic        c;
      logic        o;
      logic        err;
      int          lat;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   start_cyc [2];
   int   abort_cnt [2];
   bit   busy [2];
   int   ua_rem, ub_rem;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pow_arbiter_if #(.N(N)) ia ();
   pow_arbiter_if #(.N(N)) ib ();

   pow_arbiter #(.N(N), .TIMEOUT(40000)) dut_a (.clk(clk), .rst(rst), .bus(ia));
   pow_arbiter #(.N(N), .TIMEOUT(8))     dut_b (.clk(clk), .rst(rst), .bus(ib));

   // Signed power with 32-bit wraparound; {result, cflag, oflag}.
   function automatic logic [33:0] pow_ref(input logic [15:0] b, input logic [15:0] e);
      longint acc;
      logic   o;
      if (e[15] || (b == 16'd0 && e == 16'd0)) return {32'd0, 1'b1, 1'b0};
      acc = 1;
      o   = 1'b0;
      for (int i = 0; i < int'(e); i++) begin
         acc = acc * longint'($signed(b));
         if (acc > 64'sd2147483647 || acc < -64'sd2147483648) o = 1'b1;
         acc = longint'($signed(acc[31:0]));
      end
      return {acc[31:0], 1'b0, o};
   endfunction

   // pow unit model A: ready e+1 cycles after start (1 for negative expo).
   always @(posedge clk) begin
      if (rst || ia.pow_abort) begin
         ia.pow_ready <= 1'b0;
         {ia.pow_result, ia.pow_cflag, ia.pow_oflag} <= '0;
         ua_rem <= 0;
      end else begin
         ia.pow_ready <= 1'b0;
         if (ia.pow_start) begin
            if (ia.pow_expo[15] || ia.pow_expo == 16'd0) begin
               ia.pow_ready <= 1'b1;
               {ia.pow_result, ia.pow_cflag, ia.pow_oflag} <= pow_ref(ia.pow_base, ia.pow_expo);
            end else ua_rem <= int'(ia.pow_expo);
         end else if (ua_rem > 0) begin
            if (ua_rem == 1) begin
               ia.pow_ready <= 1'b1;
               {ia.pow_result, ia.pow_cflag, ia.pow_oflag} <= pow_ref(ia.pow_base, ia.pow_expo);
            end
            ua_rem <= ua_rem - 1;
         end
      end
   end

   // pow unit model B, same behaviour.
   always @(posedge clk) begin
      if (rst || ib.pow_abort) begin
         ib.pow_ready <= 1'b0;
         {ib.pow_result, ib.pow_cflag, ib.pow_oflag} <= '0;
         ub_rem <= 0;
      end else begin
         ib.pow_ready <= 1'b0;
         if (ib.pow_start) begin
            if (ib.pow_expo[15] || ib.pow_expo == 16'd0) begin
               ib.pow_ready <= 1'b1;
               {ib.pow_result, ib.pow_cflag, ib.pow_oflag} <= pow_ref(ib.pow_base, ib.pow_expo);
            end else ub_rem <= int'(ib.pow_expo);
         end else if (ub_rem > 0) begin
            if (ub_rem == 1) begin
               ib.pow_ready <= 1'b1;
               {ib.pow_result, ib.pow_cflag, ib.pow_oflag} <= pow_ref(ib.pow_base, ib.pow_expo);
            end
            ub_rem <= ub_rem - 1;
         end
      end
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // An ack is legal only when no operation is outstanding, one-hot, and to a valid requester.
   task automatic ack_mon(input int sel, input logic [N-1:0] ack, input logic [N-1:0] valid,
                          input logic rv);
      if (ack != '0) begin
         checks++;
         if (busy[sel] || !$onehot(ack) || (ack & ~valid) != '0) begin
            errors++;
            $display("FAIL ack_legal[%0d]: got ack %b valid %b busy %0d", sel, ack, valid,
                     busy[sel]);
         end
         busy[sel] = 1'b1;
      end
      if (rv) busy[sel] = 1'b0;
   endtask

   always @(negedge clk) begin
      if (ia.pow_start) start_cyc[0] = cyc;
      if (ib.pow_start) start_cyc[1] = cyc;
      if (ia.pow_abort) abort_cnt[0]++;
      if (ib.pow_abort) abort_cnt[1]++;
      if (rst) begin
         busy[0] = 1'b0;
         busy[1] = 1'b0;
      end else begin
         ack_mon(0, ia.req_ack, ia.req_valid, ia.rsp_valid);
         ack_mon(1, ib.req_ack, ib.req_valid, ib.rsp_valid);
      end
   end

   task automatic set_req(input int sel, input int id, input logic v, input logic [15:0] b,
                          input logic [15:0] e);
      if (sel == 0) begin
         ia.req_valid[id] = v;
         ia.req_base[16*id +: 16] = b;
         ia.req_expo[16*id +: 16] = e;
      end else begin
         ib.req_valid[id] = v;
         ib.req_base[16*id +: 16] = b;
         ib.req_expo[16*id +: 16] = e;
      end
   endtask

   function automatic logic [N-1:0] get_ack(input int sel);
      return (sel == 0) ? ia.req_ack : ib.req_ack;
   endfunction

   function automatic rsp_t get_rsp(input int sel);
      if (sel == 0)
         return {ia.rsp_valid, ia.rsp_id, ia.rsp_result, ia.rsp_cflag, ia.rsp_oflag, ia.rsp_err};
      return {ib.rsp_valid, ib.rsp_id, ib.rsp_result, ib.rsp_cflag, ib.rsp_oflag, ib.rsp_err};
   endfunction

   function automatic logic [75:0] outs(input int sel);
      if (sel == 0)
         return {ia.req_ack, ia.rsp_valid, ia.rsp_id, ia.rsp_result, ia.rsp_cflag, ia.rsp_oflag,
                 ia.rsp_err, ia.pow_start, ia.pow_base, ia.pow_expo, ia.pow_abort};
      return {ib.req_ack, ib.rsp_valid, ib.rsp_id, ib.rsp_result, ib.rsp_cflag, ib.rsp_oflag,
              ib.rsp_err, ib.pow_start, ib.pow_base, ib.pow_expo, ib.pow_abort};
   endfunction

   task automatic pulse_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Wait (bounded) for the ack of requester id at a negedge; returns its cycle, -1 on timeout.
   task automatic wait_ack(input int sel, input int id, output int a_cyc);
      logic [N-1:0] ack;
      a_cyc = -1;
      for (int t = 0; t < 100 && a_cyc < 0; t++) begin
         @(negedge clk);
         ack = get_ack(sel);
         if (ack[id]) a_cyc = cyc;
      end
      if (a_cyc < 0) begin
         checks++;
         errors++;
         $display("FAIL ack_timeout[%0d]: got no ack for id %0d required one", sel, id);
      end
   endtask

   task automatic run_op(input int sel, input int id, input logic [15:0] b, input logic [15:0] e,
                         output rsp_t r, output int a_cyc, output int lat);
      bit got;
      @(posedge clk);
      #1 set_req(sel, id, 1'b1, b, e);
      wait_ack(sel, id, a_cyc);
      @(posedge clk);
      #1 set_req(sel, id, 1'b0, b, e);
      got = 1'b0;
      lat = -1;
      r   = '0;
      for (int t = 0; t < 300 && !got; t++) begin
         @(negedge clk);
         r = get_rsp(sel);
         if (r.valid) begin
            got = 1'b1;
            lat = cyc - a_cyc;
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL rsp_timeout[%0d]: got no rsp_valid for id %0d required one", sel, id);
      end
   endtask

   vec_t        vecs[$];
   rsp_t        r;
   int          a_cyc, lat, ab0;
   int          ids[$];
   logic [N-1:0] valid_m, ack;
   logic [15:0] mb [N];
   logic [15:0] me [N];
   logic [33:0] exp_v;
   int          ptr_m, done, o_id, w, nrsp;
   logic [15:0] ob, oe;

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      ia.req_valid = '0; ia.req_base = '0; ia.req_expo = '0;
      ib.req_valid = '0; ib.req_base = '0; ib.req_expo = '0;

      vecs.push_back('{0, 0, 16'd3,    16'd4,    32'd81,         1'b0, 1'b0, 1'b0, 7});
      vecs.push_back('{0, 2, 16'hFFFE, 16'd3,    32'hFFFF_FFF8,  1'b0, 1'b0, 1'b0, 6});
      vecs.push_back('{0, 1, 16'd0,    16'd0,    32'd0,          1'b1, 1'b0, 1'b0, 3});
      vecs.push_back('{0, 3, 16'd5,    16'h8000, 32'd0,          1'b1, 1'b0, 1'b0, 3});
      vecs.push_back('{0, 0, 16'd2,    16'd31,   32'h8000_0000,  1'b0, 1'b1, 1'b0, 34});
      vecs.push_back('{0, 1, 16'hFFFE, 16'd31,   32'h8000_0000,  1'b0, 1'b0, 1'b0, 34});
      vecs.push_back('{0, 3, 16'hFFFD, 16'd5,    32'hFFFF_FF0D,  1'b0, 1'b0, 1'b0, 8});
      vecs.push_back('{0, 2, 16'd0,    16'd5,    32'd0,          1'b0, 1'b0, 1'b0, 8});
      vecs.push_back('{1, 1, 16'd1,    16'd20,   32'd0,          1'b0, 1'b0, 1'b1, 11});
      vecs.push_back('{1, 2, 16'd2,    16'd2,    32'd4,          1'b0, 1'b0, 1'b0, 5});

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_outs_a", 64'(outs(0)), 64'd0);
      check("reset_outs_b", 64'(outs(1)), 64'd0);

      foreach (vecs[i]) begin
         ab0 = abort_cnt[vecs[i].sel];
         run_op(vecs[i].sel, vecs[i].id, vecs[i].b, vecs[i].e, r, a_cyc, lat);
         check($sformatf("v%0d_result", i), 64'(r.result), 64'(vecs[i].r));
         check($sformatf("v%0d_c_o_err", i), 64'({r.c, r.o, r.err}),
               64'({vecs[i].c, vecs[i].o, vecs[i].err}));
         check($sformatf("v%0d_id", i), 64'(r.id), 64'(vecs[i].id));
         check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
         check($sformatf("v%0d_start_cycle", i), 64'(start_cyc[vecs[i].sel]), 64'(a_cyc + 1));
         check($sformatf("v%0d_abort_pulses", i), 64'(abort_cnt[vecs[i].sel] - ab0),
               64'(vecs[i].err ? 1 : 0));
      end

      // All four held valid from rr_ptr=0: service order 0,1,2,3,0.
      pulse_reset();
      for (int i = 0; i < 4; i++) set_req(0, i, 1'b1, 16'(i + 1), 16'd2);
      nrsp = 0;
      for (int t = 0; t < 300 && nrsp < 5; t++) begin
         @(negedge clk);
         r = get_rsp(0);
         if (r.valid) begin
            nrsp++;
            ids.push_back(int'(r.id));
            check("rr_result", 64'(r.result), 64'((r.id + 1) * (r.id + 1)));
            if (nrsp == 5) ia.req_valid = '0;
         end
      end
      check("rr_count", 64'(nrsp), 64'd5);
      for (int i = 0; i < 5 && i < ids.size(); i++)
         check($sformatf("rr_order%0d", i), 64'(ids[i]), 64'(i % 4));

      // Reset in WAIT on dut_b: no response, outputs back to 0.
      @(posedge clk);
      #1 set_req(1, 0, 1'b1, 16'd2, 16'd10);
      wait_ack(1, 0, a_cyc);
      @(posedge clk);
      #1 set_req(1, 0, 1'b0, 16'd2, 16'd10);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("midreset_outs_b", 64'(outs(1)), 64'd0);
      nrsp = 0;
      for (int t = 0; t < 30; t++) begin
         @(negedge clk);
         if (ib.rsp_valid) nrsp++;
      end
      check("midreset_no_rsp", 64'(nrsp), 64'd0);

      // Randomized contention on dut_a against the round-robin rule and pow_ref.
      pulse_reset();
      valid_m = '0;
      ptr_m = 0;
      done = 0;
      o_id = 0;
      ob = '0;
      oe = '0;
      for (int c = 0; c < 20000 && done < 40; c++) begin
         @(negedge clk);
         ack = ia.req_ack;
         if (ack != '0) begin
            w = -1;
            for (int k = 0; k < int'(N) && w < 0; k++)
               if (valid_m[(ptr_m + k) % N]) w = (ptr_m + k) % N;
            check("rand_grant", 64'(ack), (w < 0) ? 64'd0 : (64'd1 << w));
            if (w >= 0) begin
               o_id = w;
               ob = mb[w];
               oe = me[w];
               valid_m[w] = 1'b0;
            end
         end
         if (ia.rsp_valid) begin
            exp_v = pow_ref(ob, oe);
            check("rand_id", 64'(ia.rsp_id), 64'(o_id));
            check("rand_rsp", 64'({ia.rsp_result, ia.rsp_cflag, ia.rsp_oflag, ia.rsp_err}),
                  64'({exp_v, 1'b0}));
            ptr_m = (o_id + 1) % N;
            done++;
         end
         @(posedge clk);
         #1;
         for (int i = 0; i < int'(N); i++) begin
            if (!valid_m[i] && $urandom_range(0, 3) == 0) begin
               mb[i] = 16'(int'($urandom_range(0, 40)) - 20);
               if ($urandom_range(0, 4) == 0) me[i] = 16'h8000 | 16'($urandom_range(0, 32767));
               else me[i] = 16'($urandom_range(0, 9));
               valid_m[i] = 1'b1;
               ia.req_base[16*i +: 16] = mb[i];
               ia.req_expo[16*i +: 16] = me[i];
            end
         end
         ia.req_valid = valid_m;
      end
      ia.req_valid = '0;
      check("rand_done", 64'(done), 64'd40);
      repeat (60) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
